ex_hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the EX-stage ALU of the 5-stage MIPS32 core. Tracks in-flight destinations

---
 rtl/mips_pkg.sv | 60 ++++++
 rtl/hazard_decode.sv | 92 +++++++++
 rtl/ex_hazard_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_ex_hazard_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS32 decode constants, forwarding selects and
// hazard-tracker types for the EX-stage sequencer.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;

  localparam logic [1:0] FWD_REG   = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_FROZEN = 2'd2
  } fsm_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       is_load;
    logic       is_branch;
    logic       is_ovf_op;
  } trk_t;

  // A source hits an entry only on a live, non-zero destination.
  function automatic logic trk_hit(
    input logic [4:0] src,
    input trk_t       ent
  );
    return ent.valid && (ent.dest != 5'd0) &&
           (src == ent.dest);
  endfunction

  // Youngest producer wins: EX/MEM result over MEM/WB result.
  function automatic logic [1:0] fwd_pick(
    input logic hit_ex,
    input logic hit_mem
  );
    if (hit_ex)
      return FWD_EXMEM;
    if (hit_mem)
      return FWD_MEMWB;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/hazard_decode.sv
// Combinational MIPS32 decode of the register-hazard view of one
// instruction: destination, sources and class flags.
module hazard_decode
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  dest,
  output logic [4:0]  src_a,
  output logic [4:0]  src_b,
  output logic        uses_b,
  output logic        is_load,
  output logic        is_branch,
  output logic        is_ovf_op
);

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;

  logic op_r;
  logic op_addi;
  logic op_imm;
  logic op_lw;
  logic op_sw;
  logic op_br;

  // The shift-amount field never affects hazards.
  logic unused_shamt;

  assign op = instr[31:26];
  assign rs = instr[25:21];
  assign rt = instr[20:16];
  assign rd = instr[15:11];
  assign fn = instr[5:0];

  assign unused_shamt = ^instr[10:6];

  assign op_r    = (op == OP_RTYPE);
  assign op_addi = (op == OP_ADDI);
  assign op_imm  = (op == OP_ADDIU) ||
                   (op == OP_SLTI)  ||
                   (op == OP_SLTIU) ||
                   (op == OP_ANDI)  ||
                   (op == OP_ORI)   ||
                   (op == OP_XORI);
  assign op_lw   = (op == OP_LW);
  assign op_sw   = (op == OP_SW);
  assign op_br   = (op == OP_BEQ) ||
                   (op == OP_BNE);

  // Opcode classes are disjoint; unknown opcodes read rs only.
  always_comb begin
    dest      = 5'd0;
    src_a     = rs;
    src_b     = rt;
    uses_b    = 1'b0;
    is_load   = 1'b0;
    is_branch = 1'b0;
    is_ovf_op = 1'b0;
    unique case (1'b1)
      op_r: begin
        dest      = rd;
        uses_b    = 1'b1;
        is_ovf_op = (fn == FN_ADD) ||
                    (fn == FN_SUB);
      end
      op_addi: begin
        dest      = rt;
        is_ovf_op = 1'b1;
      end
      op_imm: begin
        dest = rt;
      end
      op_lw: begin
        dest    = rt;
        is_load = 1'b1;
      end
      op_sw: begin
        uses_b = 1'b1;
      end
      op_br: begin
        uses_b    = 1'b1;
        is_branch = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard sequencer: stalls, flushes, traps and forwarding.
// Define HAZ_FORWARD_EN to enable ALU operand forwarding.
module ex_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            id_instr,
  input  logic                   id_valid,
  input  logic [2:0]             ex_flags,
  input  logic                   mem_stall,
  output logic                   stall,
  output logic                   bubble_ex,
  output logic                   flush_ifid,
  output logic [1:0]             fwd_a_sel,
  output logic [1:0]             fwd_b_sel,
  output logic                   exc_ovf,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic [4:0] id_dest;
  logic [4:0] id_src_a;
  logic [4:0] id_src_b;
  logic       id_uses_b;
  logic       id_is_load;
  logic       id_is_branch;
  logic       id_is_ovf;

  trk_t trk_ex;
  trk_t trk_mem;
  trk_t trk_wb;
  trk_t id_ent;
  trk_t ex_retire;

  fsm_t state;
  fsm_t prev_state;

  logic hit_ex_a;
  logic hit_ex_b;
  logic hit_mem_a;
  logic hit_mem_b;
  logic ex_hit;
  logic load_use;
  logic data_haz;
  logic trap;
  logic br_taken;
  logic flush;
  logic haz;
`ifndef HAZ_FORWARD_EN
  logic mem_hit;
`endif

  // WB entry and the neg flag are carried for visibility only.
  logic unused_trk;

  assign unused_trk = ^{ex_flags[1], trk_wb,
                        trk_mem.is_load,
                        trk_mem.is_branch,
                        trk_mem.is_ovf_op};

  hazard_decode u_dec (
    .instr     (id_instr),
    .dest      (id_dest),
    .src_a     (id_src_a),
    .src_b     (id_src_b),
    .uses_b    (id_uses_b),
    .is_load   (id_is_load),
    .is_branch (id_is_branch),
    .is_ovf_op (id_is_ovf)
  );

  // Entry the ID instruction would occupy in EX.
  always_comb begin
    id_ent           = '0;
    id_ent.valid     = 1'b1;
    id_ent.dest      = id_dest;
    id_ent.is_load   = id_is_load;
    id_ent.is_branch = id_is_branch;
    id_ent.is_ovf_op = id_is_ovf;
  end

  // ID source matches against the older in-flight destinations.
  always_comb begin
    hit_ex_a  = trk_hit(id_src_a, trk_ex);
    hit_ex_b  = id_uses_b &&
                trk_hit(id_src_b, trk_ex);
    hit_mem_a = trk_hit(id_src_a, trk_mem);
    hit_mem_b = id_uses_b &&
                trk_hit(id_src_b, trk_mem);
    ex_hit    = id_valid && (hit_ex_a || hit_ex_b);
    load_use  = ex_hit && trk_ex.is_load;
  end

`ifdef HAZ_FORWARD_EN
  assign data_haz = load_use;
`else
  assign mem_hit  = id_valid && (hit_mem_a || hit_mem_b);
  assign data_haz = ex_hit || mem_hit || load_use;
`endif

  // Priority: mem_stall, overflow trap, taken branch, data hazard.
  always_comb begin
    trap     = !rst && !mem_stall &&
               trk_ex.valid && trk_ex.is_ovf_op &&
               ex_flags[0];
    br_taken = !rst && !mem_stall &&
               trk_ex.valid && trk_ex.is_branch &&
               ex_flags[2] && !trap;
    flush    = trap || br_taken;
    haz      = !rst && !mem_stall && !flush &&
               data_haz;
  end

  assign stall      = (!rst && mem_stall) || haz;
  assign bubble_ex  = flush || haz;
  assign flush_ifid = flush;
  assign exc_ovf    = trap;

  // A trapping instruction leaves EX without a destination.
  always_comb begin
    ex_retire       = trk_ex;
    ex_retire.valid = trk_ex.valid && !trap;
  end

  // Shift the EX/MEM/WB tracker unless memory freezes the pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trk_ex  <= '0;
      trk_mem <= '0;
      trk_wb  <= '0;
    end else if (!mem_stall) begin
      trk_wb  <= trk_mem;
      trk_mem <= ex_retire;
      if (bubble_ex || !id_valid)
        trk_ex <= '0;
      else
        trk_ex <= id_ent;
    end
  end

`ifdef HAZ_FORWARD_EN
  // Operand selects for the instruction entering EX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_a_sel <= FWD_REG;
      fwd_b_sel <= FWD_REG;
    end else if (!mem_stall) begin
      if (bubble_ex || !id_valid) begin
        fwd_a_sel <= FWD_REG;
        fwd_b_sel <= FWD_REG;
      end else begin
        fwd_a_sel <= fwd_pick(hit_ex_a, hit_mem_a);
        fwd_b_sel <= fwd_pick(hit_ex_b, hit_mem_b);
      end
    end
  end
`else
  assign fwd_a_sel = FWD_REG;
  assign fwd_b_sel = FWD_REG;
`endif

  // Sequencer state; FROZEN remembers where to resume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_RUN;
      prev_state <= ST_RUN;
    end else if (mem_stall) begin
      if (state != ST_FROZEN)
        prev_state <= state;
      state <= ST_FROZEN;
    end else if (state == ST_FROZEN) begin
      state <= prev_state;
    end else begin
      state <= haz ? ST_STALL : ST_RUN;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != '1))
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
  end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Self-checking bench for ex_hazard_ctrl against an instruction-level
// pipeline model; follows HAZ_FORWARD_EN like the design.
module tb_ex_hazard_ctrl;

  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
`ifdef HAZ_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic [31:0]   id_instr;
  logic          id_valid;
  logic [2:0]    ex_flags;
  logic          mem_stall;
  logic          stall;
  logic          bubble_ex;
  logic          flush_ifid;
  logic [1:0]    fwd_a_sel;
  logic [1:0]    fwd_b_sel;
  logic          exc_ovf;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  // Model: instruction words held in EX, MEM, WB.
  bit          mv[3];
  logic [31:0] mi[3];
  logic [1:0]  mfa;
  logic [1:0]  mfb;
  int          mcnt;
  bit          e_stall;
  bit          e_bub;
  bit          e_flush;
  bit          e_exc;
  logic        o_stall;
  logic        o_flush;
  logic        o_exc;
  logic        o_bub;

  ex_hazard_ctrl #(.STALL_CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .id_instr   (id_instr),
    .id_valid   (id_valid),
    .ex_flags   (ex_flags),
    .mem_stall  (mem_stall),
    .stall      (stall),
    .bubble_ex  (bubble_ex),
    .flush_ifid (flush_ifid),
    .fwd_a_sel  (fwd_a_sel),
    .fwd_b_sel  (fwd_b_sel),
    .exc_ovf    (exc_ovf),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_op(
    input logic [4:0] rs, input logic [4:0] rt,
    input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_op(
    input logic [5:0] op, input logic [4:0] rs,
    input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [4:0] wr_reg(input logic [31:0] i);
    case (i[31:26])
      6'd0: return i[15:11];
      6'd8, 6'd9, 6'd10, 6'd11,
      6'd12, 6'd13, 6'd14, 6'd35: return i[20:16];
      default: return 5'd0;
    endcase
  endfunction

  function automatic bit reads_rt(input logic [31:0] i);
    return i[31:26] inside {6'd0, 6'd4, 6'd5, 6'd43};
  endfunction

  function automatic bit reads(input logic [31:0] i,
                               input logic [4:0] r);
    return (r != 0) && ((i[25:21] == r) ||
           (reads_rt(i) && i[20:16] == r));
  endfunction

  function automatic bit ovf_op(input logic [31:0] i);
    return (i[31:26] == 6'd8) || (i[31:26] == 6'd0 &&
           (i[5:0] == 6'h20 || i[5:0] == 6'h22));
  endfunction

  function automatic logic [1:0] src_sel(input logic [4:0] r);
    if (r == 0) return 2'd0;
    if (mv[0] && wr_reg(mi[0]) == r) return 2'd1;
    if (mv[1] && wr_reg(mi[1]) == r) return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mv[k] = 1'b0;
      mi[k] = '0;
    end
    mfa = 0; mfb = 0; mcnt = 0;
    e_stall = 0; e_bub = 0; e_flush = 0; e_exc = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    id_instr = '0; id_valid = 0;
    ex_flags = '0; mem_stall = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_stall", stall, 0);
    check("rst_bubble", bubble_ex, 0);
    check("rst_flush", flush_ifid, 0);
    check("rst_exc", exc_ovf, 0);
    check("rst_fwd", {fwd_a_sel, fwd_b_sel}, 0);
    check("rst_cnt", stall_cnt, 0);
    rst = 1'b0;
  endtask

  task automatic cyc(input logic [31:0] ins, input logic iv,
                     input logic [2:0] fl, input logic ms);
    bit trap, br, dex, dmem, hz, haz;
    @(negedge clk);
    id_instr = ins; id_valid = iv;
    ex_flags = fl; mem_stall = ms;
    #1;
    trap = !ms && mv[0] && ovf_op(mi[0]) && fl[0];
    br   = !ms && mv[0] && (mi[0][31:27] == 5'b00010) &&
           fl[2] && !trap;
    dex  = iv && mv[0] && reads(ins, wr_reg(mi[0]));
    dmem = iv && mv[1] && reads(ins, wr_reg(mi[1]));
    if (FWD) hz = dex && (mi[0][31:26] == 6'd35);
    else     hz = dex || dmem;
    haz = !ms && !(trap || br) && hz;
    e_stall = ms || haz;
    e_bub   = trap || br || haz;
    e_flush = trap || br;
    e_exc   = trap;
    o_stall = stall; o_flush = flush_ifid;
    o_exc = exc_ovf; o_bub = bubble_ex;
    check("stall", stall, e_stall);
    check("bubble_ex", bubble_ex, e_bub);
    check("flush_ifid", flush_ifid, e_flush);
    check("exc_ovf", exc_ovf, e_exc);
    check("fwd_a_sel", fwd_a_sel, mfa);
    check("fwd_b_sel", fwd_b_sel, mfb);
    check("stall_cnt", stall_cnt, mcnt);
    @(posedge clk);
    if (e_stall && mcnt != CMAX) mcnt++;
    if (!ms) begin
      if (FWD && iv && !e_bub) begin
        mfa = src_sel(ins[25:21]);
        mfb = reads_rt(ins) ? src_sel(ins[20:16]) : 2'd0;
      end else begin
        mfa = 0; mfb = 0;
      end
      mv[2] = mv[1]; mi[2] = mi[1];
      mv[1] = mv[0] && !trap; mi[1] = mi[0];
      mv[0] = iv && !e_bub; mi[0] = ins;
    end
  endtask

  // Present one instruction until it leaves ID (bounded).
  task automatic issue(input logic [31:0] ins,
                       input logic [2:0] fl);
    int n;
    cyc(ins, 1'b1, fl, 1'b0);
    n = 1;
    while (e_stall && n < 8) begin
      cyc(ins, 1'b1, fl, 1'b0);
      n++;
    end
    check("issue_accept", o_stall, 0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] a, b, d;
    a = 5'($urandom_range(0, 3));
    b = 5'($urandom_range(0, 3));
    d = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 9))
      0: return r_op(a, b, d, 6'h20);
      1: return r_op(a, b, d, 6'h22);
      2: return r_op(a, b, d, 6'h24);
      3: return i_op(6'd8, a, d, 16'd1);
      4: return i_op(6'd13, a, d, 16'd7);
      5: return i_op(6'd35, a, d, 16'd0);
      6: return i_op(6'd43, a, b, 16'd4);
      7: return i_op(6'd4, a, b, 16'd2);
      8: return i_op(6'd5, a, b, 16'd2);
      default: return {6'd2, 26'($urandom)};
    endcase
  endfunction

  logic [31:0] add3, sub4, lw6, add7, beq12, addi8;
  logic [31:0] add10, lw6b, ins;
  logic        iv;

  initial begin
    add3  = r_op(5'd1, 5'd2, 5'd3, 6'h20);
    sub4  = r_op(5'd3, 5'd5, 5'd4, 6'h22);
    lw6   = i_op(6'd35, 5'd1, 5'd6, 16'd0);
    lw6b  = i_op(6'd35, 5'd4, 5'd6, 16'd0);
    add7  = r_op(5'd6, 5'd6, 5'd7, 6'h20);
    beq12 = i_op(6'd4, 5'd1, 5'd2, 16'd4);
    addi8 = i_op(6'd8, 5'd9, 5'd8, 16'd1);
    add10 = r_op(5'd8, 5'd8, 5'd10, 6'h20);

    do_reset();
    issue(add3, 3'b000);
    issue(sub4, 3'b000);
    #1;
    check("t1_fwd_a", fwd_a_sel, FWD ? 1 : 0);
    check("t1_cnt", stall_cnt, FWD ? 0 : 2);
    cyc('0, 1'b0, 3'b000, 1'b0);

    do_reset();
    issue(lw6, 3'b000);
    issue(add7, 3'b000);
    #1;
    check("t2_fwd_a", fwd_a_sel, FWD ? 2 : 0);
    check("t2_fwd_b", fwd_b_sel, FWD ? 2 : 0);
    check("t2_cnt", stall_cnt, FWD ? 1 : 2);

    do_reset();
    issue(beq12, 3'b000);
    cyc(add3, 1'b1, 3'b100, 1'b0);
    check("t3_flush", o_flush, 1);
    check("t3_bubble", o_bub, 1);
    issue(beq12, 3'b000);
    cyc(add3, 1'b1, 3'b000, 1'b0);
    check("t3_noflush", o_flush, 0);

    do_reset();
    issue(addi8, 3'b000);
    cyc(add10, 1'b1, 3'b001, 1'b0);
    check("t4_exc", o_exc, 1);
    check("t4_flush", o_flush, 1);
    check("t4_stall", o_stall, 0);
    issue(add10, 3'b000);
    #1;
    check("t4_nofwd", fwd_a_sel, 0);
    check("t4_cnt", stall_cnt, 0);
    cyc('0, 1'b0, 3'b000, 1'b0);
    check("t4_pulse", o_exc, 0);

    do_reset();
    issue(lw6, 3'b000);
    repeat (3) cyc(add7, 1'b1, 3'b000, 1'b1);
    check("t5_frz_bub", o_bub, 0);
    issue(add7, 3'b000);
    #1;
    check("t5_fwd_a", fwd_a_sel, FWD ? 2 : 0);
    check("t5_cnt", stall_cnt, FWD ? 4 : 5);

    do_reset();
    issue(add3, 3'b000);
    issue(sub4, 3'b000);
    cyc('0, 1'b0, 3'b000, 1'b1);
    issue(lw6b, 3'b000);
    @(negedge clk);
    id_instr = add7; id_valid = 1;
    ex_flags = 0; mem_stall = 0;
    #1;
    check("t6_pre_stall", stall, 1);
    rst = 1'b1;
    #1;
    check("t6_stall", stall, 0);
    check("t6_bubble", bubble_ex, 0);
    check("t6_fwd_a", fwd_a_sel, 0);
    check("t6_cnt", stall_cnt, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    do_reset();
    repeat (20) cyc('0, 1'b0, 3'b000, 1'b1);
    #1;
    check("sat_cnt", stall_cnt, CMAX);
    cyc('0, 1'b0, 3'b000, 1'b1);
    #1;
    check("sat_hold", stall_cnt, CMAX);

    ins = '0;
    iv = 1'b0;
    for (int r = 0; r < 600; r++) begin
      if (r % 50 == 0) do_reset();
      if (!e_stall) begin
        ins = rand_instr();
        iv = ($urandom_range(0, 7) != 0);
      end
      cyc(ins, iv, 3'($urandom_range(0, 7)),
          ($urandom_range(0, 9) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
